// File: rtl/spi_pkg.sv
// Shared SPI frame definitions: frame length, R/W bit position, bit-counter width.
package spi_pkg;

    typedef enum logic {
        RW_READ  = 1'b0,
        RW_WRITE = 1'b1
    } rw_e;

    localparam int MIN_SYNC_FLOPS = 2;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int cnt_width(input int flen);
        return $clog2(flen + 1);
    endfunction

    // The R/W bit arrives first, so it ends up at the top of the shift register.
    function automatic int rw_pos(input int flen);
        return flen - 1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI input with rise/fall detect on the last two stages.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic IDLE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;

    // Stages reset to the line's idle level so no false edge appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{IDLE}};
        end else begin
            sync <= {sync[STAGES-2:0], din};
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = sync[STAGES-2] & ~sync[STAGES-1];
    assign fall  = ~sync[STAGES-2] & sync[STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral with a small register bank: one R/W bit, address, data per frame.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int SYNC_FLOPS = 2,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int NUM_REGS   = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SCLK,
    input  logic                       COPI,
    input  logic                       nCS,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int CNT_W     = cnt_width(FRAME_LEN);
    localparam int RW_POS    = rw_pos(FRAME_LEN);

    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  ADDR_CNT   = CNT_W'(ADDR_W);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic sclk_level, sclk_rise, sclk_fall;
    logic copi_level, copi_rise, copi_fall;
    logic cs_level, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_FLOPS), .IDLE(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(SCLK),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_FLOPS), .IDLE(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(COPI),
        .level(copi_level), .rise(copi_rise), .fall(copi_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_FLOPS), .IDLE(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(nCS),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    // Only edges of SCLK and the level of COPI matter; the rest is intentionally dropped.
    logic sync_unused;
    assign sync_unused = ^{sclk_level, copi_rise, copi_fall};

    logic [DATA_W-1:0]    regs [NUM_REGS];
    logic [CNT_W-1:0]     cnt;
    logic [FRAME_LEN-1:0] shift;
    logic [FRAME_LEN-1:0] shift_next;
    logic                 capture;
    logic                 commit_pending;
    logic [DATA_W-1:0]    out_shift;
    logic                 rd_active;
    logic                 cipo;
    logic [DATA_W-1:0]    rd_value;
    logic [ADDR_W-1:0]    frame_addr;
    logic [DATA_W-1:0]    frame_data;
    logic                 frame_in_range;

    assign capture        = sclk_rise && !cs_level && (cnt < LAST_CNT);
    assign shift_next     = {shift[FRAME_LEN-2:0], copi_level};
    assign frame_addr     = shift[DATA_W +: ADDR_W];
    assign frame_data     = shift[DATA_W-1:0];
    assign frame_in_range = {1'b0, frame_addr} < NUM_REGS_W;

    // Unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_next[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_value = regs[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            shift          <= '0;
            commit_pending <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            frame_err      <= 1'b0;
            commit_pending <= 1'b0;
            if (cs_fall) begin
                cnt   <= '0;
                shift <= '0;
            end else if (cs_rise) begin
                cnt       <= '0;
                frame_err <= (cnt != '0) && (cnt < LAST_CNT);
            end else if (capture) begin
                shift          <= shift_next;
                cnt            <= cnt + 1'b1;
                commit_pending <= (cnt == LAST_CNT - 1'b1);
            end
        end
    end

    // The commit lands one cycle after the final bit, so a new frame starting now sees a clean counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (commit_pending && rw_e'(shift[RW_POS]) == RW_WRITE && frame_in_range) begin
                wr_strobe <= 1'b1;
                wr_addr   <= frame_addr;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (frame_addr == ADDR_W'(i)) begin
                        regs[i] <= frame_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_shift <= '0;
            rd_active <= 1'b0;
            cipo      <= 1'b0;
        end else if (cs_fall || cs_rise) begin
            out_shift <= '0;
            rd_active <= 1'b0;
            cipo      <= 1'b0;
        end else if (capture && cnt == ADDR_CNT && rw_e'(shift_next[ADDR_W]) == RW_READ) begin
            out_shift <= rd_value;
            rd_active <= 1'b1;
        end else if (sclk_fall && rd_active) begin
            cipo      <= out_shift[DATA_W-1];
            out_shift <= out_shift << 1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

    assign CIPO    = cipo;
    assign cipo_oe = ~cs_level;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed frame table, hand-written reset/abort sequences, random frames vs a register model.
`timescale 1ns/1ps
module tb_spi_reg_bank;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int HALF     = 500;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SCLK = 1'b0;
    logic COPI = 1'b0;
    logic nCS = 1'b1;
    logic CIPO, cipo_oe, wr_strobe, frame_err;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [ADDR_W-1:0] wr_addr;

    always #10 clk = ~clk;

    spi_reg_bank #(.SYNC_FLOPS(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    logic [DATA_W-1:0] strobe_data;
    logic [DATA_W-1:0] model_regs [NUM_REGS];

    // Count high cycles of each pulse; a pulse wider than one clk shows up as an extra count.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            strobe_data = regs_flat[int'(wr_addr)*DATA_W +: DATA_W];
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model_regs[i];
        return f;
    endfunction

    // Frame semantics in plain terms: captured bits, then write/read/abort outcome.
    task automatic model_frame(input logic [31:0] pat, input int nedges,
                               output int exp_strobe, output int exp_err, output logic [7:0] exp_rdata);
        int captured;
        int addr;
        logic [15:0] f;
        logic [7:0] value;
        captured   = (nedges > 16) ? 16 : nedges;
        f          = pat[31:16];
        addr       = int'(f[14:8]);
        exp_strobe = 0;
        exp_err    = (captured > 0 && captured < 16) ? 1 : 0;
        exp_rdata  = 8'h00;
        if (f[15] == 1'b0 && captured >= 8) begin
            value = (addr < NUM_REGS) ? model_regs[addr] : 8'h00;
            for (int k = 0; k < captured - 8; k++) exp_rdata[7-k] = value[7-k];
        end
        if (captured == 16 && f[15] == 1'b1 && addr < NUM_REGS) begin
            model_regs[addr] = f[7:0];
            exp_strobe = 1;
        end
    endtask

    // Mode 0: COPI set while SCLK low, CIPO sampled at each rising edge.
    task automatic apply_stimulus(input logic [31:0] pat, input int nedges, input bit raise_cs,
                                  output logic [7:0] rdata, output int dstrobe, output int derr);
        int s0, e0;
        s0 = strobe_cnt;
        e0 = err_cnt;
        rdata = 8'h00;
        nCS = 1'b0;
        for (int i = 0; i < nedges; i++) begin
            COPI = pat[31-i];
            #(HALF);
            if (i == 0) check_output("cipo_oe_in_frame", cipo_oe, 1'b1);
            if (i >= 8 && i < 16) rdata[15-i] = CIPO;
            SCLK = 1'b1;
            #(HALF);
            SCLK = 1'b0;
        end
        COPI = 1'b0;
        #(HALF);
        if (raise_cs) begin
            nCS = 1'b1;
            #(HALF);
        end
        dstrobe = strobe_cnt - s0;
        derr    = err_cnt - e0;
    endtask

    typedef struct {
        logic [31:0] pat;
        int          nedges;
        int          exp_strobe;
        int          exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [7:0] rdata;
        int dstrobe, derr, ms, me;
        logic [7:0] mr;
        logic [31:0] pat;
        int nedges;

        tbl[0] = '{32'h84A5_0000, 16, 1, 0, 8'h00};
        tbl[1] = '{32'h813C_0000, 16, 1, 0, 8'h00};
        tbl[2] = '{32'h0100_0000, 16, 0, 0, 8'h3C};
        tbl[3] = '{32'h82FF_0000, 10, 0, 1, 8'h00};
        tbl[4] = '{32'hFF55_0000, 16, 0, 0, 8'h00};
        tbl[5] = '{32'h7F00_0000, 16, 0, 0, 8'h00};
        tbl[6] = '{32'h8311_FF00, 24, 1, 0, 8'h00};
        tbl[7] = '{32'h0400_0000, 16, 0, 0, 8'hA5};
        tbl[8] = '{32'h0300_0000, 16, 0, 0, 8'h11};

        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;

        #25;
        check_output("reset_regs", regs_flat, '0);
        check_output("reset_strobe", wr_strobe, 1'b0);
        check_output("reset_err", frame_err, 1'b0);
        check_output("reset_cipo", CIPO, 1'b0);
        check_output("reset_oe", cipo_oe, 1'b0);
        check_output("reset_wr_addr", wr_addr, '0);
        rst_n = 1'b1;
        #(HALF);

        for (int t = 0; t < 9; t++) begin
            model_frame(tbl[t].pat, tbl[t].nedges, ms, me, mr);
            apply_stimulus(tbl[t].pat, tbl[t].nedges, 1'b1, rdata, dstrobe, derr);
            check_output($sformatf("tbl%0d_strobe", t), dstrobe, tbl[t].exp_strobe);
            check_output($sformatf("tbl%0d_err", t), derr, tbl[t].exp_err);
            check_output($sformatf("tbl%0d_rdata", t), rdata, tbl[t].exp_rdata);
            check_output($sformatf("tbl%0d_regs", t), regs_flat, model_flat());
            check_output($sformatf("tbl%0d_cipo_idle", t), CIPO, 1'b0);
            check_output($sformatf("tbl%0d_oe_idle", t), cipo_oe, 1'b0);
            if (tbl[t].exp_strobe != 0) begin
                check_output($sformatf("tbl%0d_wr_addr", t), wr_addr, tbl[t].pat[30:24]);
                check_output($sformatf("tbl%0d_strobe_data", t), strobe_data, tbl[t].pat[23:16]);
            end
        end

        // nCS toggle with no SCLK edges must not flag an abort.
        apply_stimulus(32'h0, 0, 1'b1, rdata, dstrobe, derr);
        check_output("cs_toggle_err", derr, 0);
        check_output("cs_toggle_strobe", dstrobe, 0);

        // Reset in the middle of a frame, then a clean write.
        apply_stimulus(32'h80FF_0000, 8, 1'b0, rdata, dstrobe, derr);
        rst_n = 1'b0;
        #3;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'h00;
        check_output("midrst_regs", regs_flat, '0);
        check_output("midrst_cipo", CIPO, 1'b0);
        check_output("midrst_oe", cipo_oe, 1'b0);
        check_output("midrst_wr_addr", wr_addr, '0);
        nCS = 1'b1;
        #(HALF);
        rst_n = 1'b1;
        #(HALF);
        model_frame(32'h8066_0000, 16, ms, me, mr);
        apply_stimulus(32'h8066_0000, 16, 1'b1, rdata, dstrobe, derr);
        check_output("postrst_strobe", dstrobe, 1);
        check_output("postrst_err", derr, 0);
        check_output("postrst_regs", regs_flat, 40'h00_0000_0066);

        for (int r = 0; r < 24; r++) begin
            int sel;
            logic [6:0] addr;
            addr = ($urandom_range(0, 5) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
            pat  = {1'($urandom_range(0, 1)), addr, 8'($urandom), 16'($urandom)};
            sel  = $urandom_range(0, 9);
            if (sel < 6)      nedges = 16;
            else if (sel < 8) nedges = $urandom_range(1, 15);
            else              nedges = $urandom_range(17, 24);
            model_frame(pat, nedges, ms, me, mr);
            apply_stimulus(pat, nedges, 1'b1, rdata, dstrobe, derr);
            check_output($sformatf("rnd%0d_strobe", r), dstrobe, ms);
            check_output($sformatf("rnd%0d_err", r), derr, me);
            check_output($sformatf("rnd%0d_rdata", r), rdata, mr);
            check_output($sformatf("rnd%0d_regs", r), regs_flat, model_flat());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter SYNC_FLOPS, default 2, synchronizer depth per SPI input (minimum 2).
REQ-002 SHALL have parameter ADDR_W, default 7, address field width.
REQ-003 SHALL have parameter DATA_W, default 8, data field width and register width.
REQ-004 SHALL have parameter NUM_REGS, default 5, implemented register count (at most 2^ADDR_W).
REQ-005 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port SCLK  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-008 SHALL have port COPI  input  1  controller-out serial data.
REQ-009 SHALL have port nCS  input  1  active-low chip select.
REQ-010 SHALL have port CIPO  output  1  peripheral-out serial read data.
REQ-011 SHALL have port cipo_oe  output  1  high while synchronized nCS is low.
REQ-012 SHALL have port regs_flat  output  NUM_REGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port wr_strobe  output  1  one-clk pulse on each committed write.
REQ-014 SHALL have port wr_addr  output  ADDR_W  address of the last committed write.
REQ-015 SHALL have port frame_err  output  1  one-clk pulse on an aborted frame.

Function
REQ-016 SHALL pass SCLK, COPI and nCS each through a SYNC_FLOPS-deep synchronizer, with edge detection on the last two stages.
REQ-017 SHALL define a frame as FRAME_LEN = 1+ADDR_W+DATA_W bits, MSB first: R/W bit (1 = write), address, data.
REQ-018 SHALL start a frame on a synchronized nCS falling edge, clearing the bit counter and shift register.
REQ-019 SHALL sample synchronized COPI on each synchronized SCLK rising edge while nCS is low, until FRAME_LEN bits are captured.
REQ-020 SHALL ignore SCLK edges after the FRAME_LEN-th bit until nCS deasserts.
REQ-021 SHALL, for a write frame with address < NUM_REGS, update the register in the clk cycle after the last bit is captured; in that same cycle wr_strobe is high and wr_addr is loaded.
REQ-022 SHALL drop writes to address >= NUM_REGS, with no register change and no wr_strobe.
REQ-023 SHALL commit at most one write per frame.
REQ-024 SHALL, in a read frame, load a DATA_W output shifter when the last address bit is captured: register content, or 0 if address >= NUM_REGS.
REQ-025 SHALL drive the shifter MSB on CIPO from the first synchronized SCLK falling edge after the address phase, shifting left on each later falling edge.
REQ-026 SHALL drive CIPO 0 outside the read data phase.
REQ-027 SHALL leave registers unchanged on a read frame.
REQ-028 SHALL, when nCS rises after 1 or more and fewer than FRAME_LEN captured bits, pulse frame_err for one clk and commit nothing.
REQ-029 SHALL not pulse frame_err when nCS toggles with zero bits captured.
REQ-030 SHALL let a new frame starting in the cycle after a commit proceed normally.
REQ-031 SHALL require an SCLK high or low phase of at least SYNC_FLOPS+2 clk periods; faster SCLK is out of specification.

Reset
REQ-032 SHALL, on rst_n low, immediately clear all registers, regs_flat, wr_addr, counter, shifters and synchronizers, and drive wr_strobe, frame_err, CIPO and cipo_oe to 0.
REQ-033 SHALL, after reset is asserted mid-frame, discard the partial frame and wait for a fresh nCS falling edge.
REQ-034 SHALL initialise synchronizer stages to their idle levels on reset: nCS 1, SCLK 0, COPI 0.

Structure
REQ-035 SHALL take the R/W bit position, the FRAME_LEN computation and the bit-counter width ($clog2(FRAME_LEN+1)) from shared package spi_pkg.
REQ-036 SHALL instantiate sub-module spi_sync_edge (synchronizer plus rise/fall detect) once per SPI input.
REQ-037 SHALL keep the register array and frame control in spi_reg_bank itself.

Verification (defaults, clk 50 MHz, SCLK 1 MHz)
REQ-038 SHALL cover a write: frame 0x84A5 -> register 4 = 0xA5, a single wr_strobe pulse, wr_addr = 4, other registers 0.
REQ-039 SHALL cover a readback: write 0x813C, then read frame 0x0100 -> CIPO returns 0x3C MSB first, registers unchanged, no wr_strobe.
REQ-040 SHALL cover an abort: nCS rises after 10 bits of 0x82FF -> one frame_err pulse, register 2 stays 0.
REQ-041 SHALL cover out-of-range access: write 0xFF55 -> no change, no strobe; read 0x7F00 -> CIPO 0x00.
REQ-042 SHALL cover over-clocking: 24 SCLK edges within one nCS low carrying 0x8311 then 0xFF -> register 3 = 0x11 only.
REQ-043 SHALL cover reset mid-frame: rst_n low after 8 bits, then a full frame 0x8066 -> register 0 = 0x66, no stale bits.
